// File: rtl/i2s_transmitter.sv
// Master-mode I2S transmitter: generates bclk/lrclk and serialises one left/right
// sample pair per frame, fed through a single-entry holding register (stb/ack).
module i2s_transmitter #(
    parameter int bclk_divide = 8,
    parameter int slot_bits   = 32,
    parameter int data_bits   = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [data_bits-1:0] left_in,
    input  logic [data_bits-1:0] right_in,
    input  logic                 in_stb,
    output logic                 in_ack,
    output logic                 bclk_out,
    output logic                 lrclk_out,
    output logic                 dout_out,
    output logic                 underrun_out
);

    localparam int FRAME_BITS = 2 * slot_bits;
    localparam int DIV_W      = (bclk_divide > 1) ? $clog2(bclk_divide) : 1;
    localparam int POS_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(bclk_divide - 1);
    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(FRAME_BITS - 1);
    localparam logic [POS_W-1:0] POS_RIGHT  = POS_W'(slot_bits);

    logic [DIV_W-1:0]      r_div;
    logic [POS_W-1:0]      r_pos;
    logic [FRAME_BITS-1:0] r_shift;
    logic [data_bits-1:0]  r_left;
    logic [data_bits-1:0]  r_right;
    logic                  r_full;

    logic                  w_div_tc;
    logic                  w_fall;
    logic                  w_load;
    logic                  w_capture;
    logic [POS_W-1:0]      w_pos_next;
    logic [FRAME_BITS-1:0] w_frame;

    assign w_div_tc   = (r_div == DIV_LAST);
    assign w_fall     = w_div_tc & bclk_out;
    assign w_load     = w_fall & (r_pos == '0);
    assign w_capture  = in_stb & in_ack;
    assign w_pos_next = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;

    // Each sample is left-justified in its slot; the slot tail is zero padding.
    always_comb begin
        w_frame = '0;
        w_frame[FRAME_BITS-1 -: data_bits] = r_left;
        w_frame[slot_bits-1  -: data_bits] = r_right;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div        <= '0;
            r_pos        <= '0;
            r_shift      <= '0;
            r_left       <= '0;
            r_right      <= '0;
            r_full       <= 1'b0;
            in_ack       <= 1'b0;
            bclk_out     <= 1'b0;
            lrclk_out    <= 1'b0;
            dout_out     <= 1'b0;
            underrun_out <= 1'b0;
        end else begin
            r_div <= w_div_tc ? '0 : r_div + 1'b1;
            if (w_div_tc) begin
                bclk_out <= ~bclk_out;
            end

            // Data and word select move only on bclk falling, one bit behind lrclk.
            if (w_fall) begin
                r_pos     <= w_pos_next;
                lrclk_out <= (w_pos_next >= POS_RIGHT);
                if (w_load) begin
                    r_shift  <= r_full ? w_frame : '0;
                    dout_out <= r_full ? w_frame[FRAME_BITS-1] : 1'b0;
                end else begin
                    r_shift  <= r_shift << 1;
                    dout_out <= r_shift[FRAME_BITS-2];
                end
            end

            underrun_out <= w_load & ~r_full;

            // Load only consumes a full register and capture needs it empty,
            // so a capture coinciding with a mute load survives for the next frame.
            if (w_load && r_full) begin
                r_full <= 1'b0;
            end
            if (w_capture) begin
                r_full  <= 1'b1;
                r_left  <= left_in;
                r_right <= right_in;
            end

            in_ack <= w_capture ? 1'b0 : ~r_full;
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: one instance at divide 2 / S=32 / D=24, one at full
// rate (divide 1) with S=D=16; frames are reassembled from the pins and scored.
module tb_i2s_transmitter;

    logic        clk;
    logic        rst_n;

    logic [23:0] left_a, right_a;
    logic        in_stb_a, ack_a, bclk_a, lrclk_a, dout_a, ur_a;
    logic [15:0] left_b, right_b;
    logic        in_stb_b, ack_b, bclk_b, lrclk_b, dout_b, ur_b;

    i2s_transmitter #(.bclk_divide(2), .slot_bits(32), .data_bits(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .left_in(left_a), .right_in(right_a),
        .in_stb(in_stb_a), .in_ack(ack_a), .bclk_out(bclk_a), .lrclk_out(lrclk_a),
        .dout_out(dout_a), .underrun_out(ur_a));

    i2s_transmitter #(.bclk_divide(1), .slot_bits(16), .data_bits(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .left_in(left_b), .right_in(right_b),
        .in_stb(in_stb_b), .in_ack(ack_b), .bclk_out(bclk_b), .lrclk_out(lrclk_b),
        .dout_out(dout_b), .underrun_out(ur_b));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] frame;
        logic        ur;
    } obs_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [63:0] f;
    } vec_a_t;

    logic [63:0] exp_qa[$];
    logic [31:0] exp_qb[$];
    obs_t        obs_a[$];
    obs_t        obs_b[$];

    int n_chk  = 0;
    int n_fail = 0;
    int n_ack_a = 0;

    int ur_cnt_a = 0, ur_int_a = 0, ur_wide_a = 0, lr_err_a = 0, mon_p_a = 0;
    int ur_cnt_b = 0, ur_int_b = 0, ur_wide_b = 0, lr_err_b = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor for instance A: reassemble frames p=1..2S-1 plus next p=0
    initial begin
        int rise, cyc, last_ur, p;
        logic prev_bclk, prev_ur, ur_seen, ur_frame, started;
        logic [63:0] col;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rise = 0; cyc = 0; last_ur = -1; prev_bclk = 0; prev_ur = 0;
                ur_seen = 0; ur_frame = 0; started = 0; col = '0; mon_p_a = 0;
            end else begin
                cyc++;
                if (ur_a && prev_ur) ur_wide_a++;
                if (ur_a && !prev_ur) begin
                    ur_cnt_a++;
                    ur_seen = 1;
                    if (last_ur >= 0) ur_int_a = cyc - last_ur;
                    last_ur = cyc;
                end
                prev_ur = ur_a;
                if (bclk_a && !prev_bclk) begin
                    p = rise % 64;
                    rise++;
                    mon_p_a = p;
                    if (lrclk_a !== (p >= 32)) lr_err_a++;
                    col = {col[62:0], dout_a};
                    if (p == 1) begin
                        ur_frame = ur_seen; ur_seen = 0; started = 1;
                    end
                    if (p == 0 && started) obs_a.push_back('{frame: col, ur: ur_frame});
                end
                prev_bclk = bclk_a;
            end
        end
    end

    // monitor for instance B
    initial begin
        int rise, cyc, last_ur, p;
        logic prev_bclk, prev_ur, ur_seen, ur_frame, started;
        logic [31:0] col;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rise = 0; cyc = 0; last_ur = -1; prev_bclk = 0; prev_ur = 0;
                ur_seen = 0; ur_frame = 0; started = 0; col = '0;
            end else begin
                cyc++;
                if (ur_b && prev_ur) ur_wide_b++;
                if (ur_b && !prev_ur) begin
                    ur_cnt_b++;
                    ur_seen = 1;
                    if (last_ur >= 0) ur_int_b = cyc - last_ur;
                    last_ur = cyc;
                end
                prev_ur = ur_b;
                if (bclk_b && !prev_bclk) begin
                    p = rise % 32;
                    rise++;
                    if (lrclk_b !== (p >= 16)) lr_err_b++;
                    col = {col[30:0], dout_b};
                    if (p == 1) begin
                        ur_frame = ur_seen; ur_seen = 0; started = 1;
                    end
                    if (p == 0 && started) obs_b.push_back('{frame: {32'h0, col}, ur: ur_frame});
                end
                prev_bclk = bclk_b;
            end
        end
    end

    // driver tasks
    task automatic send_a(input logic [23:0] l, input logic [23:0] r, input logic [63:0] f);
        bit ok = 0;
        @(negedge clk);
        left_a = l; right_a = r; in_stb_a = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            if (ack_a) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin
            exp_qa.push_back(f);
            n_ack_a++;
            @(posedge clk);
        end else begin
            chk("ack_timeout_a", 64'd0, 64'd1);
        end
    endtask

    task automatic send_b(input logic [15:0] l, input logic [15:0] r, input logic [31:0] f);
        bit ok = 0;
        @(negedge clk);
        left_b = l; right_b = r; in_stb_b = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (ack_b) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin
            exp_qb.push_back(f);
            @(posedge clk);
        end else begin
            chk("ack_timeout_b", 64'd0, 64'd1);
        end
    endtask

    // scoreboard: muted frames must be zero, others pop the expected queue
    task automatic drain_a();
        obs_t o;
        while (obs_a.size() > 0) begin
            o = obs_a.pop_front();
            if (o.ur) chk("mute_frame_a", o.frame, 64'd0);
            else if (exp_qa.size() == 0) chk("unexpected_frame_a", o.frame, 64'hx);
            else chk("frame_a", o.frame, exp_qa.pop_front());
        end
    endtask

    task automatic drain_b();
        obs_t o;
        while (obs_b.size() > 0) begin
            o = obs_b.pop_front();
            if (o.ur) chk("mute_frame_b", o.frame, 64'd0);
            else if (exp_qb.size() == 0) chk("unexpected_frame_b", o.frame, 64'hx);
            else chk("frame_b", o.frame, {32'h0, exp_qb.pop_front()});
        end
    endtask

    task automatic wait_drain(input int limit);
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            drain_a();
            drain_b();
            if (exp_qa.size() == 0 && exp_qb.size() == 0) break;
        end
        chk("exp_a_empty", 64'(exp_qa.size()), 64'd0);
        chk("exp_b_empty", 64'(exp_qb.size()), 64'd0);
    endtask

    initial begin
        vec_a_t tbl[4];
        bit hit;
        tbl[0] = '{24'hABCDEF, 24'h123456, 64'hABCDEF00_12345600};
        tbl[1] = '{24'h800000, 24'h7FFFFF, 64'h80000000_7FFFFF00};
        tbl[2] = '{24'hFFFFFF, 24'h000001, 64'hFFFFFF00_00000100};
        tbl[3] = '{24'h555555, 24'hAAAAAA, 64'h55555500_AAAAAA00};

        rst_n = 1'b0;
        in_stb_a = 1'b1; left_a = 24'h111111; right_a = 24'h222222;
        in_stb_b = 1'b1; left_b = 16'h3333;   right_b = 16'h4444;
        repeat (3) @(negedge clk);
        chk("reset_outs_a", {59'd0, bclk_a, lrclk_a, dout_a, ack_a, ur_a}, 64'd0);
        chk("reset_outs_b", {59'd0, bclk_b, lrclk_b, dout_b, ack_b, ur_b}, 64'd0);
        in_stb_a = 1'b0;
        in_stb_b = 1'b0;
        rst_n = 1'b1;

        @(negedge clk);
        chk("ack_edge1_a", {63'd0, ack_a}, 64'd1);
        chk("ack_edge1_b", {63'd0, ack_b}, 64'd1);
        chk("bclk_edge1_a", {63'd0, bclk_a}, 64'd0);
        chk("bclk_edge1_b", {63'd0, bclk_b}, 64'd1);
        @(negedge clk);
        chk("bclk_edge2_a", {63'd0, bclk_a}, 64'd1);

        // underrun: no samples offered
        repeat (800) @(negedge clk);
        chk("underrun_count_a", {63'd0, ur_cnt_a >= 3}, 64'd1);
        chk("underrun_period_a", 64'(ur_int_a), 64'd256);
        chk("underrun_period_b", 64'(ur_int_b), 64'd64);
        chk("frames_seen_a", {63'd0, obs_a.size() >= 2}, 64'd1);
        drain_a();
        drain_b();

        // table vectors with stb held high across pairs (backpressure)
        for (int i = 0; i < 4; i++) send_a(tbl[i].l, tbl[i].r, tbl[i].f);
        @(negedge clk);
        in_stb_a = 1'b0;
        chk("acks_a", 64'(n_ack_a), 64'd4);
        wait_drain(3000);

        // last-bit carry at full rate: right LSB at p=0, next left MSB at p=1
        send_b(16'h0000, 16'h0001, 32'h0000_0001);
        send_b(16'h8000, 16'h1234, 32'h8000_1234);
        send_b(16'h7FFF, 16'hFFFF, 32'h7FFF_FFFF);
        @(negedge clk);
        in_stb_b = 1'b0;
        wait_drain(1000);

        // reset mid-frame with one pair in flight and one held
        send_a(24'h5A5A5A, 24'hA5A5A5, 64'h5A5A5A00_A5A5A500);
        send_a(24'h3C3C3C, 24'hC3C3C3, 64'h3C3C3C00_C3C3C300);
        @(negedge clk);
        in_stb_a = 1'b0;
        hit = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            drain_a();
            drain_b();
            if (mon_p_a == 40) begin hit = 1; break; end
        end
        chk("reached_p40_a", {63'd0, hit}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_outs_a", {59'd0, bclk_a, lrclk_a, dout_a, ack_a, ur_a}, 64'd0);
        chk("midreset_outs_b", {59'd0, bclk_b, lrclk_b, dout_b, ack_b, ur_b}, 64'd0);
        exp_qa.delete();
        exp_qb.delete();
        repeat (3) @(negedge clk);
        obs_a.delete();
        obs_b.delete();
        rst_n = 1'b1;
        repeat (700) @(negedge clk);
        chk("post_reset_frames_a", {63'd0, obs_a.size() >= 2}, 64'd1);
        drain_a();
        drain_b();

        chk("lrclk_a", 64'(lr_err_a), 64'd0);
        chk("lrclk_b", 64'(lr_err_b), 64'd0);
        chk("underrun_width_a", 64'(ur_wide_a), 64'd0);
        chk("underrun_width_b", 64'(ur_wide_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Master-mode I2S transmitter that drives an external stereo audio DAC. It is the output-direction counterpart of the external ADC receive path (bclk/lrclk/dout inputs). It generates the bit clock and word-select, and serialises left/right samples delivered by the transceiver audio path over a stb/ack handshake. It sits in the transceiver clock domain and feeds top-level pins.

## Interface
- `bclk_divide`, default 8: clk cycles per bclk half-period. Must be ≥1. bclk = clk/(2·bclk_divide).
- `slot_bits`, default 32: bclk periods per channel slot (S).
- `data_bits`, default 24: sample width (D). Requires D ≤ S.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `left_in`  in  D  left sample, two's complement.
- `right_in`  in  D  right sample, two's complement.
- `in_stb`  in  1  sample pair valid.
- `in_ack`  out  1  holding register empty; transfer occurs on a clk edge with `in_stb & in_ack`.
- `bclk_out`  out  1  bit clock; DAC samples on its rising edge.
- `lrclk_out`  out  1  word select; 0 = left, 1 = right.
- `dout_out`  out  1  serial data, MSB first.
- `underrun_out`  out  1  one-clk pulse when a frame starts with no sample available.

## Operation
- Divider counter runs 0..bclk_divide−1. On terminal count it wraps to 0 and bclk_out toggles.
- Frame position p runs 0..2S−1. It advances (wrapping 2S−1→0) on every bclk falling toggle. All of lrclk_out, dout_out and p update on the same clk edge as the falling toggle.
- lrclk_out = 0 for p in 0..S−1 and 1 for p in S..2S−1.
- Frame word F (2S bits) = {left, S−D zeros, right, S−D zeros}.
- dout_out at position p = F[2S−1−((p−1) mod 2S)]. This gives the standard I2S one-bit delay: the left MSB appears at p=1, and p=0 carries the last bit of the previous frame.
- Holding register: one sample pair plus a full flag.
  - in_ack = registered !full.
  - On `in_stb & in_ack`, capture left_in/right_in and set full. in_ack is low from the next cycle.
- Frame load occurs on the falling toggle that moves p 0→1.
  - If full: the 2S-bit shift register is loaded from the holding register and full clears. in_ack rises on the following cycle.
  - If empty: the shift register is loaded with all zeros (mute) and underrun_out pulses for exactly that one cycle.
- A capture and a frame load can never collide: capture needs full=0, and load only consumes a full register. A capture landing on the same edge as a load that sees empty is kept for the next frame.

## Timing
- Reset values (asynchronous on rst_n low): bclk_out=0, lrclk_out=0, dout_out=0, in_ack=0, underrun_out=0, divider=0, p=0, full=0, shift register=0.
- in_ack goes to 1 on the first clk edge after rst_n deasserts.
- First bclk rising edge: bclk_divide clk edges after reset release. First falling edge (p 0→1, first frame load): 2·bclk_divide edges after release.
- Latency from accepted sample to its left MSB on dout_out: up to one frame (2S·2·bclk_divide clk) plus wait for p 0→1.
- Throughput: at most one accepted pair per frame. The sample rate is clk/(4·S·bclk_divide); at 50 MHz, divide 8, S 32 this is 48.828 kHz.
- dout_out and lrclk_out change only with bclk falling, so they are stable across each rising edge.
- bclk_divide=1: bclk toggles every clk; the full-rate path must still meet the above ordering.
- Reset mid-frame: all outputs go to reset values immediately and the held sample is discarded. Operation restarts from p=0.

## Test plan
- Reset: hold rst_n=0 with in_stb=1 → all outputs 0. After release, in_ack=1 next cycle and the first bclk rise comes after exactly bclk_divide clk.
- Single frame, D=24, S=32, divide=2: left=0xABCDEF, right=0x123456 → dout bits p=1..24 = 0xABCDEF MSB-first, p=25..32 = 0, p=33..56 = 0x123456, p=57..63 and next p=0 = 0. lrclk toggles at p=32 and p=0. No underrun.
- Underrun: no in_stb after reset → dout constant 0, underrun_out pulses once per frame (every 2·32·2·2=256 clk at divide 2), one clk wide.
- Backpressure: in_stb held high with pairs A, B, C → each acked once, one per frame. A, B, C appear in order with no repeats or drops.
- Last-bit carry, D=S=16: right=0x0001 followed by left=0x8000 → dout=1 at p=0 of the next frame and 1 at p=1.
- Reset mid-frame at p=40 → outputs 0 within the same cycle. After release, the previously held sample is never transmitted and the first frame underruns unless a new stb arrives.
